// File: rtl/mc_datapath_core.sv
// mc_datapath_core
//   Multicycle MIPS datapath. Holds PC and the non-architectural registers
//   (IR, MDR, A, B, ALUOut), the ALU and the SrcA/SrcB/next-PC muxes. All
//   sequencing comes from the external main/ALU decoder; a control word
//   applied in cycle n takes effect at the edge that ends cycle n.
// Ports
//   CLK, RESET            clock, synchronous active-low reset
//   IrD, PCSr, ALUSrA,
//   ALUSrB, ALUControl,
//   IRWr, PCWr, Brnch,
//   MemWr, RegWr,
//   Mem2Reg, RegDs        decoder control word
//   MemAddr/MemWData/
//   MemWE, MemRData       unified instruction/data memory (async read)
//   RA1/RA2/WA3/WD3/
//   RegWE, RD1/RD2        register file (async read)
//   Op, Funct, Zero       status back to the decoder
module mc_datapath_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IrD,
  input  logic [1:0]  PCSr,
  input  logic        ALUSrA,
  input  logic [1:0]  ALUSrB,
  input  logic [2:0]  ALUControl,
  input  logic        IRWr,
  input  logic        PCWr,
  input  logic        Brnch,
  input  logic        MemWr,
  input  logic        RegWr,
  input  logic        Mem2Reg,
  input  logic        RegDs,
  input  logic [31:0] MemRData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWE,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic [4:0]  RA1,
  output logic [4:0]  RA2,
  output logic [4:0]  WA3,
  output logic [31:0] WD3,
  output logic        RegWE,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        Zero
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] sign_imm, src_a, src_b, alu_res, pc_next;
  logic        pc_en;

  assign sign_imm = {{16{ir[15]}}, ir[15:0]};
  assign src_a    = ALUSrA ? a : pc;

  always_comb begin
    src_b = b;
    case (ALUSrB)
      2'b00:   src_b = b;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = {sign_imm[29:0], 2'b00};
    endcase
  end

  // Unassigned ALU codes deliberately produce 0 (and so assert Zero).
  always_comb begin
    alu_res = '0;
    case (ALUControl)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

  assign Zero = (alu_res == 32'd0);

  // Code 11 is reserved and simply re-selects the current PC.
  always_comb begin
    pc_next = pc;
    case (PCSr)
      2'b00:   pc_next = alu_res;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = pc;
    endcase
  end

  // Branch uses this cycle's combinational Zero, not a registered copy.
  assign pc_en = PCWr | (Brnch & Zero);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= MemRData;
      a       <= RD1;
      b       <= RD2;
      alu_out <= alu_res;
      if (IRWr)  ir <= MemRData;
      if (pc_en) pc <= pc_next;
    end
  end

  assign MemAddr  = IrD ? alu_out : pc;
  assign MemWData = b;
  assign MemWE    = MemWr & RESET;
  assign RA1      = ir[25:21];
  assign RA2      = ir[20:16];
  assign WA3      = RegDs ? ir[15:11] : ir[20:16];
  assign WD3      = Mem2Reg ? mdr : alu_out;
  assign RegWE    = RegWr & RESET;
  assign Op       = ir[31:26];
  assign Funct    = ir[5:0];

endmodule

// File: tb/tb_mc_datapath_core.sv
// Directed bench for mc_datapath_core: small word memory model, register
// file read data driven directly by each step.
module tb_mc_datapath_core;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IrD, ALUSrA, IRWr, PCWr, Brnch, MemWr, RegWr, Mem2Reg, RegDs;
  logic [1:0]  PCSr, ALUSrB;
  logic [2:0]  ALUControl;
  logic [31:0] MemRData, MemAddr, MemWData, RD1, RD2, WD3;
  logic        MemWE, RegWE, Zero;
  logic [4:0]  RA1, RA2, WA3;
  logic [5:0]  Op, Funct;

  logic [31:0] mem [0:63];
  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  assign MemRData = mem[MemAddr[7:2]];

  mc_datapath_core #(.RESET_PC(32'h0000_0040)) dut (
    .CLK(CLK), .RESET(RESET), .IrD(IrD), .PCSr(PCSr), .ALUSrA(ALUSrA),
    .ALUSrB(ALUSrB), .ALUControl(ALUControl), .IRWr(IRWr), .PCWr(PCWr),
    .Brnch(Brnch), .MemWr(MemWr), .RegWr(RegWr), .Mem2Reg(Mem2Reg),
    .RegDs(RegDs), .MemRData(MemRData), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWE(MemWE), .RD1(RD1), .RD2(RD2), .RA1(RA1),
    .RA2(RA2), .WA3(WA3), .WD3(WD3), .RegWE(RegWE), .Op(Op), .Funct(Funct),
    .Zero(Zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IrD = 0; PCSr = 2'b00; ALUSrA = 0; ALUSrB = 2'b00; ALUControl = 3'b000;
    IRWr = 0; PCWr = 0; Brnch = 0; MemWr = 0; RegWr = 0; Mem2Reg = 0; RegDs = 0;
  endtask

  task automatic fetch();
    idle();
    IRWr = 1; PCWr = 1; ALUSrB = 2'b01; ALUControl = 3'b010;
  endtask

  task automatic decode();
    idle();
    ALUSrB = 2'b11; ALUControl = 3'b010;
  endtask

  task automatic branch();
    idle();
    ALUSrA = 1; ALUControl = 3'b110; PCSr = 2'b01; Brnch = 1;
  endtask

  task automatic do_reset();
    RESET = 0; tick(); RESET = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h8C02_0008;   // 0x40: lw $2,8($0)
    mem[2]  = 32'hDEAD_BEEF;   // 0x08
    mem[17] = 32'h0800_0010;   // 0x44: j 0x40 (region-relative)
    RD1 = 0; RD2 = 0;
    idle();

    // Reset, with MemWr held high
    RESET = 0; MemWr = 1;
    tick(); tick();
    check("rst_memwe", {31'd0, MemWE}, 32'd0);
    check("rst_pc", MemAddr, 32'h40);
    check("rst_op", {26'd0, Op}, 32'd0);
    check("rst_funct", {26'd0, Funct}, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    RESET = 1;

    // lw fetch
    fetch();
    check("lw_fetch_addr", MemAddr, 32'h40);
    tick();
    check("lw_op", {26'd0, Op}, 32'h23);
    check("lw_funct", {26'd0, Funct}, 32'h08);
    check("lw_ra1", {27'd0, RA1}, 32'd0);
    check("lw_ra2", {27'd0, RA2}, 32'd2);
    check("lw_pc", MemAddr, 32'h44);

    // decode: ALUOut = 0x44 + (8<<2)
    decode(); RD1 = 32'h0; RD2 = 32'h1111_1111;
    tick();
    IrD = 1; #1;
    check("lw_dec_aluout", MemAddr, 32'h64);

    // memaddr: A + SignImm
    idle(); ALUSrA = 1; ALUSrB = 2'b10; ALUControl = 3'b010;
    tick();
    // memread
    IrD = 1; #1;
    check("lw_rd_addr", MemAddr, 32'h8);
    tick();
    // writeback
    idle(); RegWr = 1; Mem2Reg = 1; #1;
    check("lw_wa3", {27'd0, WA3}, 32'd2);
    check("lw_wd3", WD3, 32'hDEAD_BEEF);
    check("lw_regwe", {31'd0, RegWE}, 32'd1);
    check("lw_wdata", MemWData, 32'h1111_1111);
    RegDs = 1; #1;
    check("lw_wa3_rd", {27'd0, WA3}, 32'd0);
    tick();

    // beq taken from 0x40
    mem[16] = 32'h1085_0003;
    do_reset();
    fetch(); tick();
    decode(); RD1 = 5; RD2 = 5;
    tick();
    check("beq_ra1", {27'd0, RA1}, 32'd4);
    check("beq_ra2", {27'd0, RA2}, 32'd5);
    branch(); #1;
    check("beq_zero_t", {31'd0, Zero}, 32'd1);
    tick();
    idle(); #1;
    check("beq_pc_t", MemAddr, 32'h50);

    // beq not taken
    do_reset();
    fetch(); tick();
    decode(); RD1 = 5; RD2 = 6;
    tick();
    branch(); RD1 = 32'h1000_0000; #1;
    check("beq_zero_nt", {31'd0, Zero}, 32'd0);
    tick();
    idle(); #1;
    check("beq_pc_nt", MemAddr, 32'h44);

    // IR and PC written at the same edge: IR <= mem[0x44], PC <= A+4
    fetch(); ALUSrA = 1;
    tick();
    check("sim_op", {26'd0, Op}, 32'h02);
    check("sim_pc", MemAddr, 32'h1000_0004);

    // jump
    idle(); PCSr = 2'b10; PCWr = 1; RD1 = 32'hFFFF_FFFF; RD2 = 32'h1;
    tick();
    check("j_pc", MemAddr, 32'h1000_0040);

    // slt signed: -1 < 1
    idle(); ALUSrA = 1; ALUControl = 3'b111; RD1 = 32'h7FFF_FFFF; RD2 = 32'h1; #1;
    check("slt_zero", {31'd0, Zero}, 32'd0);
    tick();
    IrD = 1; #1;
    check("slt_res", MemAddr, 32'h1);

    // add wraps
    idle(); ALUSrA = 1; ALUControl = 3'b010; RD1 = 32'hF0F0_F0F0; RD2 = 32'h0FF0_0FF0;
    tick();
    IrD = 1; #1;
    check("add_wrap", MemAddr, 32'h8000_0000);

    ALUControl = 3'b001; tick(); #1;
    check("or_res", MemAddr, 32'hFFF0_FFF0);
    ALUControl = 3'b000; tick(); #1;
    check("and_res", MemAddr, 32'h00F0_00F0);
    ALUControl = 3'b110; tick(); #1;
    check("sub_res", MemAddr, 32'hE100_E100);
    ALUControl = 3'b101; #1;
    check("undef_zero", {31'd0, Zero}, 32'd1);
    MemWr = 1; #1;
    check("memwe_on", {31'd0, MemWE}, 32'd1);

    // reset mid memread
    RESET = 0; RegWr = 1; ALUControl = 3'b110; #1;
    check("mid_memwe", {31'd0, MemWE}, 32'd0);
    check("mid_regwe", {31'd0, RegWE}, 32'd0);
    tick();
    check("mid_aluout", MemAddr, 32'h0);
    check("mid_op", {26'd0, Op}, 32'd0);
    RESET = 1;
    fetch(); #1;
    check("mid_fetch_addr", MemAddr, 32'h40);
    tick();
    check("mid_fetch_op", {26'd0, Op}, 32'h04);
    check("mid_fetch_pc", MemAddr, 32'h44);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/mc_datapath_core.md
# mc_datapath_core

Multicycle MIPS datapath core: the consumer end of the main-decoder control interface. It holds the PC and the non-architectural registers (IR, MDR, A, B, ALUOut), contains the ALU and the source/next-PC multiplexers, and drives the unified instruction/data memory and the register-file ports. It sits between the main/ALU decoder (which drives its control inputs) and the memory and register file. It returns Op, Funct and Zero to the decoder.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low reset.
- IrD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- PCSr  in  2  next-PC select.
- ALUSrA  in  1  SrcA select: 0 = PC, 1 = A.
- ALUSrB  in  2  SrcB select.
- ALUControl  in  3  ALU operation, supplied by the ALU decoder.
- IRWr, PCWr, Brnch, MemWr, RegWr, Mem2Reg, RegDs  in  1 each  decoder control signals.
- MemRData  in  32  memory read data, combinational from MemAddr.
- MemAddr  out  32  memory address.
- MemWData  out  32  memory write data.
- MemWE  out  1  memory write enable.
- RD1, RD2  in  32  register-file read data, combinational.
- RA1, RA2, WA3  out  5  register-file addresses.
- WD3  out  32  register-file write data.
- RegWE  out  1  register-file write enable.
- Op, Funct  out  6  IR[31:26], IR[5:0].
- Zero  out  1  ALUResult == 0.

## Operation
- State registers: PC, IR, MDR, A, B, ALUOut, all 32 bits.
- On every edge with RESET=1, these registers always load:
  - MDR <= MemRData
  - A <= RD1
  - B <= RD2
  - ALUOut <= ALUResult
- IR loads MemRData only when IRWr=1.
- PC loads PCNext when PCWr | (Brnch & Zero).
- SignImm = sign-extend IR[15:0].
- SrcB select:
  - 00 = B
  - 01 = 32'd4
  - 10 = SignImm
  - 11 = SignImm<<2
- ALUControl operations:
  - 010 = add
  - 110 = sub
  - 000 = and
  - 001 = or
  - 111 = slt (signed; result 1 or 0)
  - 011, 100, 101 = result 0
- Arithmetic wraps modulo 2^32; no overflow flag.
- PCNext select:
  - 00 = ALUResult
  - 01 = ALUOut
  - 10 = {PC[31:28], IR[25:0], 2'b00}
  - 11 = PC (reserved, holds)
- MemAddr = IrD ? ALUOut : PC.
- MemWData = B.
- RA1 = IR[25:21]; RA2 = IR[20:16].
- WA3 = RegDs ? IR[15:11] : IR[20:16].
- WD3 = Mem2Reg ? MDR : ALUOut.
- MemWE = MemWr & RESET; RegWE = RegWr & RESET. Both are forced low while reset is asserted.
- The block has no internal FSM. Sequencing belongs to the decoder. The block guarantees that each control word applied in cycle n takes effect at the edge ending cycle n.

## Timing
- Reset (RESET=0 at an edge):
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - Op = 0, Funct = 0.
  - MemAddr = RESET_PC (IrD=0).
  - MemWE = 0, RegWE = 0.
  - Zero follows the combinational ALU result.
- Reset mid-instruction discards all in-flight state. The first cycle after deassertion is a fetch from RESET_PC.
- Fetch cycle (IrD=0, IRWr=1, ALUSrA=0, ALUSrB=01, ALUControl=010, PCSr=00, PCWr=1):
  - IR <= mem[PC] and PC <= PC+4 at the same edge.
  - Op/Funct are valid in the next cycle.
- Decode cycle: A/B capture RD1/RD2 of the new IR at the end of the cycle. ALUOut captures the branch target PC+(SignImm<<2).
- Branch-taken update uses the Zero of the current cycle, not a registered Zero.
- Memory read data reaches MDR one edge after the address cycle. Writeback of MDR occurs in the following cycle.
- Combinational paths:
  - MemAddr/MemWE to MemRData: a 1-cycle read.
  - IR to RA1/RA2 to RD1/RD2 to A/B.
- Simultaneous IRWr and PCWr are legal. Both use pre-edge values.

## Test plan
- Reset: hold RESET=0 for 2 edges with RESET_PC=32'h0000_0040 and MemWr=1 -> PC=0x40, MemWE=0, IR=0, MemAddr=0x40.
- Fetch: mem[0x40]=32'h8C02_0008 (lw $2,8($0)) with a fetch control word -> IR=0x8C020008, PC=0x44, Op=6'h23, RA1=0, RA2=2.
- lw sequence: decode, memaddr (ALUSrA=1, ALUSrB=10, add), memread (IrD=1), writeback (RegWr=1, Mem2Reg=1, RegDs=0), with mem[8]=0xDEADBEEF -> MemAddr=8 during memread; WA3=2, WD3=0xDEADBEEF, RegWE=1 during writeback.
- beq taken/not-taken: IR=0x1085_0003, RD1=RD2=5, branch cycle (ALUSrA=1, ALUSrB=00, sub, PCSr=01, Brnch=1) -> Zero=1, PC=0x44+12. Repeat with RD2=6 -> PC unchanged at 0x44.
- Jump and slt:
  - IR=0x0800_0010 with PC=0x1000_0004, PCSr=10, PCWr=1 -> PC=0x1000_0040.
  - A=0xFFFF_FFFF, B=1, ALUControl=111 -> ALUOut=1.
  - 0x7FFF_FFFF+1 -> ALUOut=0x8000_0000.
- Reset mid-operation: assert RESET=0 during the memread cycle -> IR, ALUOut=0, MemWE=0, and the next cycle fetches from RESET_PC.
